mux_serializer: RTL and testbench
=================================

# mux_serializer

Parallel-to-serial front end for the 8:1 multiplexer stage. It captures an 8-bit word through a valid/ready load port and drives the mux select through all eight positions in sequence. The selected bit is presented on a valid/ready serial port, so downstream logic receives one bit per accepted beat. It sits directly upstream of the mux and owns the select sequencing.

## Interface
- `MSB_FIRST`, default 0: 0 = select order 0→7, 1 = select order 7→0.
- `GAP_CYCLES`, default 0: number of forced idle cycles after the last bit of a word, range 0–15.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `load_valid`  in  1  `load_data` is valid.
- `load_ready`  out  1  block can accept a word.
- `load_data`  in  8  word to serialize.
- `ser_valid`  out  1  `ser_out` holds a valid bit.
- `ser_ready`  in  1  downstream accepts the bit.
- `ser_out`  out  1  current bit, `hold[sel]` through the mux.
- `ser_last`  out  1  current bit is the final bit of the word.
- `sel`  out  3  current mux select, for debug and probing.
- `busy`  out  1  state is not IDLE.

## Operation
- FSM states:
  - IDLE: `load_ready`=1.
  - SHIFT: `ser_valid`=1.
  - GAP: both ready and valid low.
- IDLE transition: when `load_valid && load_ready`, capture `load_data` into `hold`, set `sel` to the start index (0, or 7 if `MSB_FIRST`), then go to SHIFT.
- SHIFT beat: a beat is accepted when `ser_valid && ser_ready`.
  - Not the last bit: `sel` steps +1 (or −1 if `MSB_FIRST`).
  - Last bit (`sel` == 7, or 0 if `MSB_FIRST`): go to GAP with the counter loaded to `GAP_CYCLES`-1 if `GAP_CYCLES`>0, otherwise go to IDLE.
- GAP: the counter decrements each cycle; at 0 go to IDLE.
- `ser_out` is combinational from `hold` and `sel`. `ser_last` is combinational: SHIFT and `sel` equals the end index.
- `hold` and `sel` stay frozen while `ser_ready`=0. `ser_out` and `ser_last` stay stable under backpressure.
- `load_valid` outside IDLE is ignored and never captured; the word is not lost because `load_ready` is low.
- `sel` is 3-bit and never wraps mid-word; the end index ends the word explicitly.
- Reset mid-word aborts the word. No partial word is resumed.

## Timing
- Reset values:
  - State IDLE.
  - `load_ready`=1, `ser_valid`=0, `ser_last`=0, `busy`=0.
  - `sel`=0, `hold`=0, so `ser_out`=0.
  - Gap counter = 0.
- Latency: the first bit is valid the cycle after load acceptance.
- Throughput with `ser_ready`=1: 8 bits in 8 consecutive cycles.
- Word-to-word spacing: the next `load_ready` comes 1 + `GAP_CYCLES` cycles after the last-beat cycle. Minimum word period is 9 + `GAP_CYCLES` cycles.
- `busy` is registered-state derived and is high from the cycle after load acceptance until IDLE is re-entered.

## Structure
- Package `mux_pkg`:
  - state enum (IDLE, SHIFT, GAP)
  - `SEL_W`=3
  - `DATA_W`=8
- Sub-module: `eighttoonemux` (in[7:0], sel[2:0], out), instantiated with `in`=`hold` and `sel`=`sel`, output driving `ser_out`.
- The FSM, select counter and gap counter stay in `mux_serializer`.

## Test plan
- LSB-first, load `8'b00100010`, `ser_ready`=1 → `ser_out` = 0,1,0,0,0,1,0,0 on the 8 cycles after the load; `ser_last` only on the 8th; `load_ready` high on the next cycle.
- `MSB_FIRST`=1, load `8'b10000000` → `ser_out` = 1 then seven 0s; `sel` = 7,6,…,0; `ser_last` at `sel`=0.
- Backpressure, load `8'b00000101`, hold `ser_ready`=0 for 3 cycles at `sel`=2 → `ser_out`=1 and `sel`=2 stay stable; the word completes in 11 cycles total.
- `GAP_CYCLES`=3, `load_valid` held high with words `8'hEF` then `8'h80` → `load_ready` is low for exactly 3 cycles after the last beat; the second word starts 12 cycles after the first load; no word is dropped or duplicated.
- `load_valid` pulsed with `8'hFF` while in SHIFT → ignored; the current word completes unchanged.
- Assert `rst` at `sel`=4 mid-word, asynchronously between edges → all outputs take reset values immediately. After release, a new load of `8'h01` serializes correctly as 1 followed by seven 0s.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and constants for the mux serializer.
package mux_pkg;

    localparam int SEL_W  = 3;
    localparam int DATA_W = 8;
    // Gap counter width: GAP_CYCLES is limited to 0..15.
    localparam int GAP_W  = 4;

    // Serializer control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    // First select position of a word for the chosen bit order.
    function automatic logic [SEL_W-1:0] start_index(input logic msb_first);
        return msb_first ? SEL_W'(DATA_W - 1) : '0;
    endfunction

    // Final select position of a word for the chosen bit order.
    function automatic logic [SEL_W-1:0] end_index(input logic msb_first);
        return msb_first ? '0 : SEL_W'(DATA_W - 1);
    endfunction

endpackage

// File: rtl/eighttoonemux.sv
// 8:1 bit multiplexer driven by the serializer's select counter.
module eighttoonemux
    import mux_pkg::*;
(
    input  logic [DATA_W-1:0] in,
    input  logic [SEL_W-1:0]  sel,
    output logic              out
);

    // Purely combinational bit pick.
    always_comb begin
        out = in[sel];
    end

endmodule

// File: rtl/mux_serializer.sv
// Parallel-to-serial front end: captures a byte on the load port and walks
// the mux select through all eight positions, one bit per accepted beat.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. load_ready is high only in IDLE; ser_valid is high only in
// SHIFT. While ser_ready is low, hold and sel are frozen so ser_out and
// ser_last do not change under backpressure. load_valid outside IDLE is
// simply not sampled.
module mux_serializer
    import mux_pkg::*;
#(
    parameter bit          MSB_FIRST  = 1'b0,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_out,
    output logic              ser_last,
    output logic [SEL_W-1:0]  sel,
    output logic              busy,
    output state_e            state_dbg
);

    localparam logic [SEL_W-1:0] START_IDX = start_index(MSB_FIRST);
    localparam logic [SEL_W-1:0] END_IDX   = end_index(MSB_FIRST);
    // Counter preload so that GAP lasts exactly GAP_CYCLES cycles.
    localparam logic [GAP_W-1:0] GAP_LOAD  =
        (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  hold_q,  hold_d;
    logic [SEL_W-1:0]   sel_q,   sel_d;
    logic [GAP_W-1:0]   gap_q,   gap_d;

    logic beat_acc;

    // State and datapath registers; reset aborts any word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            sel_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            sel_q   <= sel_d;
            gap_q   <= gap_d;
        end
    end

    // Next-state logic, select sequencing, gap countdown and handshake outputs.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        sel_d      = sel_q;
        gap_d      = gap_q;
        load_ready = 1'b0;
        ser_valid  = 1'b0;
        beat_acc   = 1'b0;

        unique case (state_q)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    hold_d  = load_data;
                    sel_d   = START_IDX;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                ser_valid = 1'b1;
                beat_acc  = ser_ready;
                if (beat_acc) begin
                    if (sel_q == END_IDX) begin
                        // Last bit: sel stays on the end index, never wraps.
                        if (GAP_CYCLES > 0) begin
                            gap_d   = GAP_LOAD;
                            state_d = GAP;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (MSB_FIRST) begin
                        sel_d = sel_q - 1'b1;
                    end else begin
                        sel_d = sel_q + 1'b1;
                    end
                end
            end

            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status outputs derived from registered state only.
    always_comb begin
        ser_last  = (state_q == SHIFT) && (sel_q == END_IDX);
        busy      = (state_q != IDLE);
        sel       = sel_q;
        state_dbg = state_q;
    end

    eighttoonemux u_mux (
        .in  (hold_q),
        .sel (sel_q),
        .out (ser_out)
    );

endmodule

// File: tb/tb_mux_serializer.sv
// Bench for mux_serializer: three configurations share one stimulus stream
// and are checked every cycle against a word/beat-level model, with directed
// scenarios pinned by literal expectations.
module tb_mux_serializer;
  import mux_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_valid = 1'b0;
  logic       ser_ready = 1'b0;
  logic [7:0] load_data = 8'h00;

  always #5 clk = ~clk;

  logic       lr [3];
  logic       sv [3];
  logic       so [3];
  logic       sl [3];
  logic       bz [3];
  logic [2:0] sel_w [3];
  state_e     st [3];

  mux_serializer #(.MSB_FIRST(1'b0), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(lr[0]),
    .load_data(load_data), .ser_valid(sv[0]), .ser_ready(ser_ready),
    .ser_out(so[0]), .ser_last(sl[0]), .sel(sel_w[0]), .busy(bz[0]),
    .state_dbg(st[0])
  );

  mux_serializer #(.MSB_FIRST(1'b1), .GAP_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(lr[1]),
    .load_data(load_data), .ser_valid(sv[1]), .ser_ready(ser_ready),
    .ser_out(so[1]), .ser_last(sl[1]), .sel(sel_w[1]), .busy(bz[1]),
    .state_dbg(st[1])
  );

  mux_serializer #(.MSB_FIRST(1'b0), .GAP_CYCLES(3)) dut2 (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(lr[2]),
    .load_data(load_data), .ser_valid(sv[2]), .ser_ready(ser_ready),
    .ser_out(so[2]), .ser_last(sl[2]), .sel(sel_w[2]), .busy(bz[2]),
    .state_dbg(st[2])
  );

  // ---------------- reference model ----------------
  int         cfg_msb [3] = '{0, 1, 0};
  int         cfg_gap [3] = '{0, 0, 3};
  logic [7:0] m_hold [3];
  int         m_sel  [3];
  int         m_left [3];   // bits of the current word not yet accepted
  int         m_gap  [3];   // forced idle cycles still to come

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int k,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h (t=%0t)", name, k, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_hold[k] = 8'h00;
      m_sel[k]  = 0;
      m_left[k] = 0;
      m_gap[k]  = 0;
    end
  endtask

  // Advance the model by one rising edge using the inputs presented to it.
  task automatic model_step();
    if (rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 3; k++) begin
      if (m_left[k] == 0 && m_gap[k] == 0) begin
        if (load_valid) begin
          m_hold[k] = load_data;
          m_sel[k]  = cfg_msb[k] ? 7 : 0;
          m_left[k] = 8;
        end
      end else if (m_left[k] > 0) begin
        if (ser_ready) begin
          m_left[k]--;
          if (m_left[k] == 0) m_gap[k] = cfg_gap[k];
          else m_sel[k] = cfg_msb[k] ? m_sel[k] - 1 : m_sel[k] + 1;
        end
      end else begin
        m_gap[k]--;
      end
    end
  endtask

  // Compare every DUT output against the model.
  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      logic e_busy;
      logic [7:0] h;
      e_busy = (m_left[k] > 0) || (m_gap[k] > 0);
      h = m_hold[k];
      chk("load_ready", k, lr[k], !e_busy);
      chk("ser_valid",  k, sv[k], m_left[k] > 0);
      chk("ser_last",   k, sl[k], m_left[k] == 1);
      chk("busy",       k, bz[k], e_busy);
      chk("sel",        k, sel_w[k], m_sel[k]);
      chk("ser_out",    k, so[k], h[m_sel[k]]);
    end
  endtask

  // One clock: model follows the edge, outputs checked on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic any_busy();
    for (int k = 0; k < 3; k++)
      if (m_left[k] > 0 || m_gap[k] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_idle();
    int n;
    load_valid = 1'b0;
    ser_ready  = 1'b1;
    n = 0;
    while (any_busy() && n < 40) begin
      tick();
      n++;
    end
    chk("wait_idle budget", 0, any_busy(), 0);
  endtask

  task automatic load_word(input logic [7:0] d);
    load_data  = d;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [7:0]  v0, v1, v2;
  logic [15:0] v16;
  int          lastcnt, n, acc_n, beats, gaplow;
  int          acc_t [2];

  initial begin
    model_reset();
    @(negedge clk);
    compare_all();
    for (int k = 0; k < 3; k++) begin
      chk("reset load_ready", k, lr[k], 1);
      chk("reset ser_valid",  k, sv[k], 0);
      chk("reset sel",        k, sel_w[k], 0);
      chk("reset ser_out",    k, so[k], 0);
      chk("reset busy",       k, bz[k], 0);
    end
    tick();
    rst = 1'b0;
    tick();

    // LSB-first 0x22 at full rate.
    wait_idle();
    ser_ready = 1'b1;
    load_word(8'b0010_0010);
    lastcnt = 0;
    for (int i = 0; i < 8; i++) begin
      v0[i] = so[0];
      v1[i] = so[1];
      lastcnt += int'(sl[0]);
      if (i == 7) chk("lsb ser_last on 8th", 0, sl[0], 1);
      tick();
    end
    chk("lsb bits", 0, v0, 8'h22);
    chk("msb bits of 0x22", 1, v1, 8'h44);
    chk("lsb ser_last count", 0, lastcnt, 1);
    chk("lsb load_ready after word", 0, lr[0], 1);
    chk("gap3 load_ready after word", 2, lr[2], 0);

    // MSB-first 0x80: 1 then seven 0s, sel 7..0.
    wait_idle();
    load_word(8'h80);
    for (int i = 0; i < 8; i++) begin
      v0[i] = so[0];
      v1[i] = so[1];
      chk("msb sel sequence", 1, sel_w[1], 7 - i);
      if (i == 7) chk("msb ser_last at sel0", 1, sl[1], 1);
      tick();
    end
    chk("msb bits of 0x80", 1, v1, 8'h01);
    chk("lsb bits of 0x80", 0, v0, 8'h80);

    // Backpressure: 0x05 with ser_ready low for 3 cycles at sel=2.
    wait_idle();
    load_word(8'h05);
    n = 0;
    while (n < 30) begin
      n++;
      ser_ready = !(n >= 3 && n <= 5);
      if (n >= 3 && n <= 5) begin
        chk("stall ser_out", 0, so[0], 1);
        chk("stall sel", 0, sel_w[0], 2);
      end
      if (sv[0] && sl[0] && ser_ready) begin
        tick();
        break;
      end
      tick();
    end
    chk("backpressure word cycles", 0, n, 11);

    // GAP_CYCLES=3 with load_valid held high: 0xEF then 0x80.
    wait_idle();
    load_valid = 1'b1;
    load_data  = 8'hEF;
    acc_n = 0; beats = 0; gaplow = 0; v16 = '0;
    acc_t[0] = 0; acc_t[1] = 0;
    for (int t = 0; t < 40; t++) begin
      if (load_valid && lr[2] && acc_n < 2) begin
        acc_t[acc_n] = t;
        acc_n++;
      end
      if (sv[2] && ser_ready && beats < 16) begin
        v16[beats] = so[2];
        beats++;
      end
      if (acc_n == 1 && bz[2] && !sv[2]) gaplow++;
      tick();
      if (acc_n == 1) load_data = 8'h80;
      if (acc_n == 2) load_valid = 1'b0;
    end
    load_valid = 1'b0;
    chk("gap accept count", 2, acc_n, 2);
    chk("gap word spacing", 2, acc_t[1] - acc_t[0], 12);
    chk("gap load_ready low cycles", 2, gaplow, 3);
    chk("gap beats", 2, beats, 16);
    chk("gap words", 2, v16, 16'h80EF);

    // load_valid pulsed with 0xFF mid-word must be ignored.
    wait_idle();
    load_word(8'h3C);
    for (int i = 0; i < 8; i++) begin
      v0[i] = so[0];
      v2[i] = so[2];
      load_valid = (i == 2);
      load_data  = (i == 2) ? 8'hFF : 8'h3C;
      tick();
    end
    load_valid = 1'b0;
    chk("ignored load dut0", 0, v0, 8'h3C);
    chk("ignored load dut2", 2, v2, 8'h3C);

    // Asynchronous reset mid-word at sel=4, then a clean word.
    wait_idle();
    load_word(8'h5A);
    n = 0;
    while (m_sel[0] != 4 && n < 10) begin
      tick();
      n++;
    end
    chk("reached sel4", 0, sel_w[0], 4);
    #1 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("async rst load_ready", k, lr[k], 1);
      chk("async rst ser_valid",  k, sv[k], 0);
      chk("async rst ser_last",   k, sl[k], 0);
      chk("async rst busy",       k, bz[k], 0);
      chk("async rst sel",        k, sel_w[k], 0);
      chk("async rst ser_out",    k, so[k], 0);
    end
    model_reset();
    tick();
    rst = 1'b0;
    tick();
    ser_ready = 1'b1;
    load_word(8'h01);
    for (int i = 0; i < 8; i++) begin
      v0[i] = so[0];
      v1[i] = so[1];
      tick();
    end
    chk("post reset lsb", 0, v0, 8'h01);
    chk("post reset msb", 1, v1, 8'h80);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      load_valid = ($urandom_range(0, 1) == 1);
      load_data  = 8'($urandom_range(0, 255));
      ser_ready  = ($urandom_range(0, 3) != 0);
      rst        = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
